dmem_responder: RTL and testbench

- Data-memory side of the MEM-stage load/store interface: accepts word load/store requests from the pipeline over a valid/ready handshake.
- Performs the array access after a configurable number of wait states and returns read data or a write acknowledge over a second valid/ready channel.
- Replaces the pipeline-internal data array; sits between the MEM stage (initiator) and the backing word array.

---
 rtl/dmem_responder_if.sv | 32 +++
 rtl/dmem_responder.sv | 164 ++++++++++++++++
 tb/tb_dmem_responder.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
// ----------------------------------------------------------------------------
// dmem_responder_if
// Load/store channel between the MEM stage (master) and the data-memory
// responder (slave).
//   Request channel  : req_valid (M->S), req_ready (S->M), req_we, req_addr,
//                      req_wdata, req_be (M->S)
//   Response channel : rsp_valid (S->M), rsp_ready (M->S), rsp_rdata,
//                      rsp_err (S->M)
// req_addr is a byte address; req_be bit i enables byte lane 8i+7:8i.
// ----------------------------------------------------------------------------
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// ----------------------------------------------------------------------------
// dmem_responder
// Data-memory responder for the MEM stage. Accepts one word load/store at a
// time, waits WAIT_CYCLES cycles, accesses a 2**ADDR_W x 32 word array and
// returns read data (or a store acknowledge) on the response channel.
// Misaligned or out-of-range addresses return rsp_err=1 with zero data and
// never write the array.
// Ports:
//   clk  - clock, all state on rising edge
//   rst  - synchronous active-high reset (control and response registers;
//          array contents are not reset)
//   bus  - dmem_responder_if.slave: request and response channels
// Parameters:
//   ADDR_W      - word-address width
//   WAIT_CYCLES - wait states between request acceptance and access (0..15)
// ----------------------------------------------------------------------------
module dmem_responder #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic           clk,
  input  logic           rst,
  dmem_responder_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int          DEPTH    = 2 ** ADDR_W;
  localparam logic [3:0]  CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
  localparam bit          NO_WAIT  = (WAIT_CYCLES == 0);

  // Any address with a non-zero byte offset, or with bits above the word
  // index, is rejected rather than aliased onto the array.
  function automatic logic addr_err(input logic [31:0] a);
    logic [31:0] hi;
    hi = a >> (ADDR_W + 2);
    return (a[1:0] != 2'b00) || (hi != 32'd0);
  endfunction

  function automatic logic [31:0] be_merge(input logic [31:0] old_w,
                                           input logic [31:0] new_w,
                                           input logic [3:0]  be);
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
    end
    return r;
  endfunction

  state_t               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;

  logic                 we_q;
  logic [31:0]          addr_q;
  logic [31:0]          wdata_q;
  logic [3:0]           be_q;

  logic [31:0]          rdata_q;
  logic                 err_q;

  logic [31:0]          mem [DEPTH];

  logic                 req_hs;
  logic                 access;
  logic                 acc_we;
  logic [31:0]          acc_addr;
  logic [31:0]          acc_wdata;
  logic [3:0]           acc_be;
  logic                 acc_err;
  logic [ADDR_W-1:0]    acc_idx;

  assign bus.req_ready = (state_q == IDLE) && !rst;
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

  assign req_hs = bus.req_valid && bus.req_ready;

  // Next-state logic. With no wait states the access happens on the very
  // edge that accepts the request, so operands come straight off the bus;
  // otherwise they come from the captured request registers.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    access    = 1'b0;
    acc_we    = we_q;
    acc_addr  = addr_q;
    acc_wdata = wdata_q;
    acc_be    = be_q;

    case (state_q)
      IDLE: begin
        if (req_hs) begin
          if (NO_WAIT) begin
            access    = 1'b1;
            acc_we    = bus.req_we;
            acc_addr  = bus.req_addr;
            acc_wdata = bus.req_wdata;
            acc_be    = bus.req_be;
            state_d   = RESP;
          end else begin
            cnt_d   = CNT_INIT;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          access  = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign acc_err = addr_err(acc_addr);
  assign acc_idx = acc_addr[ADDR_W+1:2];

  // Control and response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (access) begin
        err_q   <= acc_err;
        rdata_q <= (acc_err || acc_we) ? 32'd0 : mem[acc_idx];
      end
    end
  end

  // Captured request; only meaningful between acceptance and access
  always_ff @(posedge clk) begin
    if (req_hs) begin
      we_q    <= bus.req_we;
      addr_q  <= bus.req_addr;
      wdata_q <= bus.req_wdata;
      be_q    <= bus.req_be;
    end
  end

  // Word array; a reset on the access edge discards the pending store
  always_ff @(posedge clk) begin
    if (access && !rst && acc_we && !acc_err) begin
      mem[acc_idx] <= be_merge(mem[acc_idx], acc_wdata, acc_be);
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// ----------------------------------------------------------------------------
// tb_dmem_responder
// Directed, table-driven bench for dmem_responder. Instance A uses
// WAIT_CYCLES=2, instance B uses WAIT_CYCLES=0; both share clk and rst.
// ----------------------------------------------------------------------------
module tb_dmem_responder;

  logic clk;
  logic rst;

  dmem_responder_if bus_a();
  dmem_responder_if bus_b();

  dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(2)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(0)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  localparam int NVEC = 13;
  vec_t vecs [NVEC];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Issue one request on A; returns response fields and latency in cycles
  // from the accepting edge (-1 if no response within the bound). If
  // rsp_ready is high the response is consumed before returning.
  task automatic req_a(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [3:0] be, output logic [31:0] rd, output logic er,
                       output int lat);
    int n;
    rd  = '0;
    er  = 1'b0;
    lat = -1;
    bus_a.req_we    = we;
    bus_a.req_addr  = addr;
    bus_a.req_wdata = wd;
    bus_a.req_be    = be;
    bus_a.req_valid = 1'b1;
    n = 0;
    while (bus_a.req_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    @(negedge clk);
    bus_a.req_valid = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      if (bus_a.rsp_valid === 1'b1) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
    if (lat > 0) begin
      rd = bus_a.rsp_rdata;
      er = bus_a.rsp_err;
      if (bus_a.rsp_ready === 1'b1) begin
        @(posedge clk);
        @(negedge clk);
      end
    end
  endtask

  task automatic req_b(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [3:0] be, output logic [31:0] rd, output logic er,
                       output int lat);
    int n;
    rd  = '0;
    er  = 1'b0;
    lat = -1;
    bus_b.req_we    = we;
    bus_b.req_addr  = addr;
    bus_b.req_wdata = wd;
    bus_b.req_be    = be;
    bus_b.req_valid = 1'b1;
    n = 0;
    while (bus_b.req_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    @(negedge clk);
    bus_b.req_valid = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      if (bus_b.rsp_valid === 1'b1) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
    if (lat > 0) begin
      rd = bus_b.rsp_rdata;
      er = bus_b.rsp_err;
      if (bus_b.rsp_ready === 1'b1) begin
        @(posedge clk);
        @(negedge clk);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          seen;

    //             we    addr           wdata          be      exp_rd         exp_err
    vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0000_0000, 1'b0};
    vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 4'h0, 32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{1'b1, 32'h0000_0020, 32'h1122_3344, 4'hF, 32'h0000_0000, 1'b0};
    vecs[3]  = '{1'b1, 32'h0000_0020, 32'hAABB_CCDD, 4'h5, 32'h0000_0000, 1'b0};
    vecs[4]  = '{1'b0, 32'h0000_0020, 32'h0000_0000, 4'hF, 32'h11BB_33DD, 1'b0};
    vecs[5]  = '{1'b0, 32'h0000_0022, 32'h0000_0000, 4'hF, 32'h0000_0000, 1'b1};
    vecs[6]  = '{1'b1, 32'h0000_0000, 32'hCAFE_F00D, 4'hF, 32'h0000_0000, 1'b0};
    vecs[7]  = '{1'b1, 32'h0000_1000, 32'h1234_5678, 4'hF, 32'h0000_0000, 1'b1};
    vecs[8]  = '{1'b0, 32'h0000_0000, 32'h0000_0000, 4'h0, 32'hCAFE_F00D, 1'b0};
    vecs[9]  = '{1'b1, 32'h0000_0030, 32'h0000_0000, 4'hF, 32'h0000_0000, 1'b0};
    vecs[10] = '{1'b1, 32'h0000_0FFC, 32'h0102_0304, 4'hF, 32'h0000_0000, 1'b0};
    vecs[11] = '{1'b0, 32'h0000_0FFC, 32'h0000_0000, 4'h0, 32'h0102_0304, 1'b0};
    vecs[12] = '{1'b0, 32'h8000_0010, 32'h0000_0000, 4'h0, 32'h0000_0000, 1'b1};

    rst = 1'b1;
    bus_a.req_valid = 1'b0; bus_a.req_we = 1'b0; bus_a.req_addr = '0;
    bus_a.req_wdata = '0;   bus_a.req_be = '0;   bus_a.rsp_ready = 1'b0;
    bus_b.req_valid = 1'b0; bus_b.req_we = 1'b0; bus_b.req_addr = '0;
    bus_b.req_wdata = '0;   bus_b.req_be = '0;   bus_b.rsp_ready = 1'b0;

    // Reset held for two rising edges
    @(negedge clk);
    @(negedge clk);
    chk("rst_rsp_valid", {31'd0, bus_a.rsp_valid}, 32'd0);
    chk("rst_rsp_err",   {31'd0, bus_a.rsp_err},   32'd0);
    chk("rst_rsp_rdata", bus_a.rsp_rdata,          32'd0);
    chk("rst_req_ready", {31'd0, bus_a.req_ready}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_req_ready_a", {31'd0, bus_a.req_ready}, 32'd1);
    chk("post_rst_req_ready_b", {31'd0, bus_b.req_ready}, 32'd1);

    // Table of directed requests on the two-wait-state instance
    bus_a.rsp_ready = 1'b1;
    for (int i = 0; i < NVEC; i++) begin
      req_a(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, rd, er, lat);
      chk($sformatf("vec%0d_lat", i),   32'(lat),      32'd3);
      chk($sformatf("vec%0d_rdata", i), rd,            vecs[i].exp_rd);
      chk($sformatf("vec%0d_err", i),   {31'd0, er},   {31'd0, vecs[i].exp_err});
    end

    // Backpressure: response must hold while rsp_ready is low
    bus_a.rsp_ready = 1'b0;
    req_a(1'b0, 32'h0000_0010, 32'h0, 4'h0, rd, er, lat);
    chk("bp_lat",   32'(lat), 32'd3);
    chk("bp_rdata", rd,       32'hDEAD_BEEF);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("bp_hold%0d_valid", c), {31'd0, bus_a.rsp_valid}, 32'd1);
      chk($sformatf("bp_hold%0d_rdata", c), bus_a.rsp_rdata,          32'hDEAD_BEEF);
      chk($sformatf("bp_hold%0d_ready", c), {31'd0, bus_a.req_ready}, 32'd0);
    end
    bus_a.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_after_valid", {31'd0, bus_a.rsp_valid}, 32'd0);
    chk("bp_after_ready", {31'd0, bus_a.req_ready}, 32'd1);
    chk("bp_after_rdata", bus_a.rsp_rdata,          32'hDEAD_BEEF);

    // Reset one cycle after accepting a store: store must be discarded
    bus_a.req_we    = 1'b1;
    bus_a.req_addr  = 32'h0000_0030;
    bus_a.req_wdata = 32'h5A5A_5A5A;
    bus_a.req_be    = 4'hF;
    bus_a.req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus_a.req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bus_a.rsp_valid === 1'b1) seen = 1;
    end
    chk("midwait_no_rsp", 32'(seen), 32'd0);
    req_a(1'b0, 32'h0000_0030, 32'h0, 4'h0, rd, er, lat);
    chk("midwait_load_lat",   32'(lat), 32'd3);
    chk("midwait_load_rdata", rd,       32'h0000_0000);
    req_a(1'b0, 32'h0000_0010, 32'h0, 4'h0, rd, er, lat);
    chk("after_rst_keep_rdata", rd, 32'hDEAD_BEEF);

    // Zero-wait-state instance
    bus_b.rsp_ready = 1'b1;
    req_b(1'b1, 32'h0000_0040, 32'h1357_2468, 4'hF, rd, er, lat);
    chk("w0_store_lat", 32'(lat),    32'd1);
    chk("w0_store_err", {31'd0, er}, 32'd0);
    req_b(1'b0, 32'h0000_0040, 32'h0, 4'h0, rd, er, lat);
    chk("w0_load_lat",   32'(lat), 32'd1);
    chk("w0_load_rdata", rd,       32'h1357_2468);
    req_b(1'b0, 32'h0000_0041, 32'h0, 4'h0, rd, er, lat);
    chk("w0_err_lat",   32'(lat),    32'd1);
    chk("w0_err_err",   {31'd0, er}, 32'd1);
    chk("w0_err_rdata", rd,          32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
